// File: rtl/uart_alu_pkg.sv
// Shared constants and FSM state encoding
// for the UART packet ALU.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [15:0] HDR_LEN = 16'd4;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_DISCARD,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/uart_alu_engine.sv
// Packet parser and add/echo engine between
// the UART receiver and transmitter.
module uart_alu_engine
  import uart_alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i
);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;

  logic        rx_fire;
  logic        is_echo;
  logic        is_add;
  logic [15:0] len_full;
  logic [31:0] addend;
  logic [31:0] res_sh;

  assign rx_ready_o = ~hold_vld_q & (state_q != ST_RESULT);
  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_data_o = hold_q;
  assign tx_valid_o = hold_vld_q;
  assign len_full = {rx_data_i, len_q[7:0]};
  assign addend = {24'd0, rx_data_i} << {idx_q, 3'b000};
  assign res_sh = acc_q >> {idx_q, 3'b000};

  always_comb begin
    is_echo = 1'b0;
    is_add  = 1'b0;
    unique case (1'b1)
      (op_q == OP_ECHO): is_echo = 1'b1;
      (op_q == OP_ADD):  is_add  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q & ~tx_ready_i;
    unique case (state_q)
      ST_OPCODE: if (rx_fire) begin
        op_d    = rx_data_i;
        state_d = ST_RSVD;
      end
      ST_RSVD: if (rx_fire) begin
        state_d = ST_LEN_LO;
      end
      ST_LEN_LO: if (rx_fire) begin
        len_d   = {8'd0, rx_data_i};
        state_d = ST_LEN_HI;
      end
      ST_LEN_HI: if (rx_fire) begin
        len_d = len_full;
        idx_d = 2'd0;
        acc_d = 32'd0;
        if (len_full <= HDR_LEN) begin
          state_d = ST_OPCODE;
        end else begin
          // Count down so LEN = 0xFFFF never wraps.
          cnt_d   = len_full - HDR_LEN;
          state_d = (is_echo | is_add) ? ST_PAYLOAD : ST_DISCARD;
        end
      end
      ST_PAYLOAD: if (rx_fire) begin
        cnt_d = cnt_q - 16'd1;
        idx_d = idx_q + 2'd1;
        if (is_echo) begin
          hold_d     = rx_data_i;
          hold_vld_d = 1'b1;
        end else begin
          acc_d = acc_q + addend;
        end
        if (cnt_q == 16'd1) begin
          idx_d   = 2'd0;
          state_d = is_add ? ST_RESULT : ST_OPCODE;
        end
      end
      ST_DISCARD: if (rx_fire) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = ST_OPCODE;
      end
      ST_RESULT: if (!hold_vld_q) begin
        hold_d     = res_sh[7:0];
        hold_vld_d = 1'b1;
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          acc_d   = 32'd0;
          state_d = ST_OPCODE;
        end
      end
      default: state_d = ST_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_OPCODE;
      op_q       <= 8'd0;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      acc_q      <= 32'd0;
      idx_q      <= 2'd0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 8x prescaled bit timing,
// one-byte valid/ready output buffer.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prescale,
  input  logic        rxd,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  logic [1:0]  sync_q;
  logic [7:0]  data_q, data_d;
  logic [7:0]  out_q, out_d;
  logic        vld_q, vld_d;
  logic [18:0] pre_q, pre_d;
  logic [3:0]  bit_q, bit_d;
  logic        rx;
  logic [18:0] bit_time;
  logic [18:0] half_time;

  assign rx = sync_q[1];
  assign bit_time = {prescale, 3'b000} - 19'd1;
  assign half_time = {1'b0, prescale, 2'b00} - 19'd2;
  assign m_axis_tdata = out_q;
  assign m_axis_tvalid = vld_q;

  always_comb begin
    data_d = data_q;
    out_d  = out_q;
    vld_d  = vld_q & ~m_axis_tready;
    pre_d  = pre_q;
    bit_d  = bit_q;
    if (pre_q != 19'd0) begin
      pre_d = pre_q - 19'd1;
    end else if (bit_q != 4'd0) begin
      if (bit_q == 4'd10) begin
        // Mid start bit: a high line means a glitch.
        if (!rx) begin
          bit_d = 4'd9;
          pre_d = bit_time;
        end else begin
          bit_d = 4'd0;
        end
      end else if (bit_q > 4'd1) begin
        bit_d  = bit_q - 4'd1;
        pre_d  = bit_time;
        data_d = {rx, data_q[7:1]};
      end else begin
        bit_d = 4'd0;
        if (rx) begin
          out_d = data_q;
          vld_d = 1'b1;
        end
      end
    end else if (!rx) begin
      pre_d = half_time;
      bit_d = 4'd10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      data_q <= 8'd0;
      out_q  <= 8'd0;
      vld_q  <= 1'b0;
      pre_q  <= 19'd0;
      bit_q  <= 4'd0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      data_q <= data_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      pre_q  <= pre_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, 8x prescaled bit timing,
// valid/ready byte input.
module uart_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prescale,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        txd
);

  logic [7:0]  sh_q, sh_d;
  logic        txd_q, txd_d;
  logic [18:0] pre_q, pre_d;
  logic [3:0]  bit_q, bit_d;
  logic [18:0] bit_time;

  assign bit_time = {prescale, 3'b000} - 19'd1;
  assign s_axis_tready = (bit_q == 4'd0) && (pre_q == 19'd0);
  assign txd = txd_q;

  always_comb begin
    sh_d  = sh_q;
    txd_d = txd_q;
    pre_d = pre_q;
    bit_d = bit_q;
    if (pre_q != 19'd0) begin
      pre_d = pre_q - 19'd1;
    end else if (bit_q == 4'd0) begin
      if (s_axis_tvalid) begin
        sh_d  = s_axis_tdata;
        txd_d = 1'b0;
        bit_d = 4'd9;
        pre_d = bit_time;
      end
    end else if (bit_q > 4'd1) begin
      bit_d = bit_q - 4'd1;
      txd_d = sh_q[0];
      sh_d  = {1'b0, sh_q[7:1]};
      pre_d = bit_time;
    end else begin
      bit_d = 4'd0;
      txd_d = 1'b1;
      pre_d = bit_time;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= 8'd0;
      txd_q <= 1'b1;
      pre_q <= 19'd0;
      bit_q <= 4'd0;
    end else begin
      sh_q  <= sh_d;
      txd_q <= txd_d;
      pre_q <= pre_d;
      bit_q <= bit_d;
    end
  end

endmodule

// File: rtl/uart_alu.sv
// UART packet ALU: receiver -> parser/engine
// -> transmitter.
module uart_alu #(
  parameter int PRESCALE = 410
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic RX_i,
  output logic TX_o
);

  localparam logic [15:0] PRE = 16'(PRESCALE);

  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  assign rst = ~rst_ni;

  uart_rx u_rx (
    .clk           (clk_i),
    .rst           (rst),
    .prescale      (PRE),
    .rxd           (RX_i),
    .m_axis_tdata  (rx_data),
    .m_axis_tvalid (rx_valid),
    .m_axis_tready (rx_ready)
  );

  uart_alu_engine u_engine (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready)
  );

  uart_tx u_tx (
    .clk           (clk_i),
    .rst           (rst),
    .prescale      (PRE),
    .s_axis_tdata  (tx_data),
    .s_axis_tvalid (tx_valid),
    .s_axis_tready (tx_ready),
    .txd           (TX_o)
  );

endmodule

// File: tb/tb_uart_alu.sv
// Directed packet bench for uart_alu with a
// serial-line byte monitor on TX_o.
module tb_uart_alu;

  localparam int P = 2;
  localparam int BIT = 8 * P;

  logic clk;
  logic rst_ni;
  logic RX_i;
  logic TX_o;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] rxq[$];

  uart_alu #(.PRESCALE(P)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .RX_i   (RX_i),
    .TX_o   (TX_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge TX_o);
      repeat (BIT / 2) @(negedge clk);
      if (TX_o == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = TX_o;
        end
        repeat (BIT) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    RX_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    RX_i = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_out(input string tag,
                            input int n,
                            input logic [63:0] w);
    int budget;
    budget = 0;
    while (rxq.size() < n && budget < 40000) begin
      @(negedge clk);
      budget++;
    end
    repeat (15 * BIT) @(negedge clk);
    chk({tag, " count"}, 64'(rxq.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (rxq.size() > 0) chk(tag, 64'(rxq.pop_front()), 64'(w[8*i +: 8]));
    end
    rxq.delete();
    chk({tag, " idle"}, 64'(TX_o), 64'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    RX_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset tx", 64'(TX_o), 64'd1);
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);

    send_word(32'h0008_00EC);
    send_word(32'hDEAD_BEEF);
    expect_out("echo", 4, 64'hDEAD_BEEF);

    send_word(32'h000C_0001);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    expect_out("add", 4, 64'h0000_0003);

    send_word(32'h000C_0001);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0002);
    expect_out("add ovf", 4, 64'h0000_0001);

    send_word(32'h0008_0055);
    send_word(32'h4433_2211);
    send_word(32'h0008_00EC);
    send_word(32'hDEAD_BEEF);
    expect_out("unknown", 4, 64'hDEAD_BEEF);

    send_word(32'h0004_00EC);
    send_word(32'h0008_00EC);
    send_word(32'hDEAD_BEEF);
    expect_out("len4", 4, 64'hDEAD_BEEF);

    send_word(32'h0006_0001);
    send_byte(8'h05);
    send_byte(8'h01);
    expect_out("partial", 4, 64'h0000_0105);

    send_word(32'h0008_00EC);
    send_word(32'hDEAD_BEEF);
    send_word(32'h000C_0001);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    expect_out("b2b", 8, 64'h0000_0003_DEAD_BEEF);

    send_word(32'h000C_0001);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (4) @(negedge clk);
    rst_ni = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    chk("rst mid tx", 64'(TX_o), 64'd1);
    rst_ni = 1'b1;
    repeat (40 * BIT) @(negedge clk);
    chk("rst no out", 64'(rxq.size()), 64'd0);
    rxq.delete();
    send_word(32'h0008_00EC);
    send_word(32'hDEAD_BEEF);
    expect_out("post rst", 4, 64'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu.md
UART_ALU -- requirements
Module: uart_alu

Interface
REQ-001 Parameter PRESCALE, default 410, meaning UART prescale value (clk_freq / (baud*8)); 31.5 MHz clock at 9600 baud.
REQ-002 Port clk_i, input, 1, meaning the single clock; all logic is rising-edge.
REQ-003 Port rst_ni, input, 1, meaning reset, asynchronous and active-low.
REQ-004 Port RX_i, input, 1, meaning UART receive line; idle high; 8N1, LSB first.
REQ-005 Port TX_o, output, 1, meaning UART transmit line; idle high; 8N1, LSB first.

Function
REQ-006 The block SHALL parse each packet as: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8], then LEN-4 payload bytes.
- LEN is the total packet length including the 4-byte header.
REQ-007 The parser FSM SHALL use these states, in order: OPCODE -> RSVD -> LEN_LO -> LEN_HI -> PAYLOAD or DISCARD -> (RESULT for add) -> OPCODE.
- Each transition occurs on one received byte, except RESULT.
REQ-008 If LEN <= 4, the FSM SHALL return to OPCODE after LEN_HI and transmit nothing.
REQ-009 Opcode 0xEC (echo): each payload byte SHALL be retransmitted unchanged, in arrival order; header bytes are not echoed.
REQ-010 Opcode 0x01 (add): payload SHALL be treated as 32-bit little-endian words.
- The sum of all words is taken modulo 2^32.
- A trailing partial word is zero-extended in its upper bytes.
REQ-011 On the last add payload byte, the FSM SHALL enter RESULT and hand the 4 sum bytes to TX, LSB first.
- The first result byte is offered to TX within 2 clock cycles of the last payload byte.
REQ-012 Any other opcode SHALL enter DISCARD, consume LEN-4 bytes, and transmit nothing.
REQ-013 TX path SHALL use an AXI-Stream-style valid/ready handshake.
- A byte transfers only when valid and ready are both high.
- Valid stays asserted and data stays stable until the transfer.
REQ-014 A one-byte holding register SHALL sit between the parser and TX.
- The RX ready signal is deasserted while the holding register is full, so no echo byte is dropped.
REQ-015 Bytes of a new packet arriving during RESULT SHALL be held off by RX ready and never lost or merged into the previous packet.
REQ-016 The payload byte counter SHALL be 16 bits and SHALL NOT wrap; LEN = 0xFFFF is legal.
REQ-017 The block SHALL instantiate uart_rx and uart_tx (8-bit data, prescale = PRESCALE).
- Their active-high reset is driven by the inverse of rst_ni.

Reset
REQ-018 While rst_ni is low, the following SHALL hold asynchronously:
- TX_o = 1.
- FSM = OPCODE.
- Accumulator, counters and LEN register = 0.
- Holding register empty; internal valid signals low.
REQ-019 On rst_ni rising, the block SHALL accept a new opcode on the next received start bit.
REQ-020 A reset mid-packet or mid-result SHALL abort the packet; no further bytes of it are transmitted.

Structure
REQ-021 A shared package uart_alu_pkg SHALL hold:
- Opcode constants OP_ECHO = 8'hEC and OP_ADD = 8'h01.
- The header length constant (4).
- The FSM state enum.
REQ-022 The packet parser/ALU FSM SHALL be one sub-module, uart_alu_engine, between the uart_rx and uart_tx instances.

Verification
REQ-023 Echo: send EC 00 08 00 EF BE AD DE -> TX emits EF BE AD DE, then idles high.
REQ-024 Add: send 01 00 0C 00 01 00 00 00 02 00 00 00 -> TX emits 03 00 00 00.
REQ-025 Add overflow: send 01 00 0C 00 FF FF FF FF 02 00 00 00 -> TX emits 01 00 00 00.
REQ-026 Unknown opcode: send 55 00 08 00 11 22 33 44, then the REQ-023 echo packet -> only EF BE AD DE is emitted.
REQ-027 Back-to-back: send the echo packet and the add packet with no idle gap -> EF BE AD DE 03 00 00 00, no bytes lost.
REQ-028 Reset: pull rst_ni low after 2 payload bytes of an add packet -> TX_o held high, nothing emitted; a following echo packet works.
